// File: rtl/imm_ext_pkg.sv
// Shared types and field geometry for the LEGv8 immediate extractor.
// Field LSB/MSB positions are instruction-word bit indices.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        D_SEXT9   = 3'd0,
        I_ZEXT12  = 3'd1,
        CB_SEXT19 = 3'd2,
        B_SEXT26  = 3'd3,
        IW_MOVZ   = 3'd4
    } imm_mode_t;

    localparam int D_LSB     = 12;
    localparam int D_MSB     = 20;
    localparam int I_LSB     = 10;
    localparam int I_MSB     = 21;
    localparam int CB_LSB    = 5;
    localparam int CB_MSB    = 23;
    localparam int B_LSB     = 0;
    localparam int B_MSB     = 25;
    localparam int IW_LSB    = 5;
    localparam int IW_MSB    = 20;
    localparam int IW_HW_LSB = 21;
    localparam int IW_HW_MSB = 22;

    localparam int D_W  = D_MSB - D_LSB + 1;
    localparam int I_W  = I_MSB - I_LSB + 1;
    localparam int CB_W = CB_MSB - CB_LSB + 1;
    localparam int B_W  = B_MSB - B_LSB + 1;
    localparam int IW_W = IW_MSB - IW_LSB + 1;

    localparam int BR_SHAMT     = 2;
    localparam int MOVZ_HW_STEP = 16;

endpackage

// File: rtl/sign_ext_param.sv
// Combinational field widener: replicates the field MSB (or zero) into
// the upper OUT_W-IN_W bits. Requires IN_W < OUT_W.
module sign_ext_param #(
    parameter int IN_W   = 9,
    parameter int OUT_W  = 64,
    parameter bit SIGNED = 1'b1
) (
    input  logic [IN_W-1:0]  fieldIn,
    output logic [OUT_W-1:0] extOut
);

    logic fillBit;

    assign fillBit = SIGNED ? fieldIn[IN_W-1] : 1'b0;
    assign extOut  = {{(OUT_W - IN_W){fillBit}}, fieldIn};

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extractor/extender with a two-entry skid stage.
// Extension happens combinationally ahead of the main/skid registers.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 6,
    parameter int BR_SCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [2:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_err,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int BR_LSH = (BR_SCALE != 0) ? BR_SHAMT : 0;

    logic [DATA_W-1:0] dExt;
    logic [DATA_W-1:0] iExt;
    logic [DATA_W-1:0] cbExt;
    logic [DATA_W-1:0] bExt;
    logic [DATA_W-1:0] movzExt;
    logic [DATA_W-1:0] cbScaled;
    logic [DATA_W-1:0] bScaled;
    logic [DATA_W-1:0] movzShifted;
    logic [1:0]        movzHw;
    logic              movzHwIllegal;
    logic [DATA_W-1:0] newImm;
    logic              newErr;
    logic              unusedInstrHi;

    sign_ext_param #(.IN_W(D_W), .OUT_W(DATA_W), .SIGNED(1'b1)) uDExt (
        .fieldIn (in_instr[D_MSB:D_LSB]),
        .extOut  (dExt)
    );

    sign_ext_param #(.IN_W(I_W), .OUT_W(DATA_W), .SIGNED(1'b0)) uIExt (
        .fieldIn (in_instr[I_MSB:I_LSB]),
        .extOut  (iExt)
    );

    sign_ext_param #(.IN_W(CB_W), .OUT_W(DATA_W), .SIGNED(1'b1)) uCbExt (
        .fieldIn (in_instr[CB_MSB:CB_LSB]),
        .extOut  (cbExt)
    );

    sign_ext_param #(.IN_W(B_W), .OUT_W(DATA_W), .SIGNED(1'b1)) uBExt (
        .fieldIn (in_instr[B_MSB:B_LSB]),
        .extOut  (bExt)
    );

    sign_ext_param #(.IN_W(IW_W), .OUT_W(DATA_W), .SIGNED(1'b0)) uMovzExt (
        .fieldIn (in_instr[IW_MSB:IW_LSB]),
        .extOut  (movzExt)
    );

    // Scaling after extension keeps the sign; bits pushed past DATA_W are lost.
    assign cbScaled    = cbExt << BR_LSH;
    assign bScaled     = bExt << BR_LSH;
    assign movzHw      = in_instr[IW_HW_MSB:IW_HW_LSB];
    assign movzShifted = movzExt << (MOVZ_HW_STEP * movzHw);

    // A 32-bit datapath only has half-word slots 0 and 1.
    assign movzHwIllegal = (DATA_W == 32) && movzHw[1];

    // Opcode bits above the widest field carry no immediate information.
    assign unusedInstrHi = ^in_instr[31:26];

    always_comb begin
        newImm = '0;
        newErr = 1'b1;
        case (in_mode)
            D_SEXT9: begin
                newImm = dExt;
                newErr = 1'b0;
            end
            I_ZEXT12: begin
                newImm = iExt;
                newErr = 1'b0;
            end
            CB_SEXT19: begin
                newImm = cbScaled;
                newErr = 1'b0;
            end
            B_SEXT26: begin
                newImm = bScaled;
                newErr = 1'b0;
            end
            IW_MOVZ: begin
                if (!movzHwIllegal) begin
                    newImm = movzShifted;
                    newErr = 1'b0;
                end
            end
            default: begin
                newImm = '0;
                newErr = 1'b1;
            end
        endcase
    end

    // Handshake: a beat transfers on any rising edge where valid && ready
    // are both high (and neither reset nor flush is asserted); out_valid
    // and its payload stay put until out_ready, and in_ready is a pure
    // register output so it never depends on out_ready in the same cycle.
    logic              mainValid;
    logic [DATA_W-1:0] mainImm;
    logic              mainErr;
    logic [TAG_W-1:0]  mainTag;
    logic              skidValid;
    logic [DATA_W-1:0] skidImm;
    logic              skidErr;
    logic [TAG_W-1:0]  skidTag;
    logic              accept;
    logic              drain;

    assign in_ready  = !skidValid;
    assign accept    = in_valid && in_ready;
    assign drain     = mainValid && out_ready;

    assign out_valid = mainValid;
    assign out_imm   = mainImm;
    assign out_err   = mainErr;
    assign out_tag   = mainTag;

    always_ff @(posedge clk) begin
        if (reset) begin
            mainValid <= 1'b0;
            mainImm   <= '0;
            mainErr   <= 1'b0;
            mainTag   <= '0;
            skidValid <= 1'b0;
            skidImm   <= '0;
            skidErr   <= 1'b0;
            skidTag   <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (drain) begin
            // skidValid implies in_ready was low, so no accept competes here.
            if (skidValid) begin
                mainImm   <= skidImm;
                mainErr   <= skidErr;
                mainTag   <= skidTag;
                skidValid <= 1'b0;
            end else if (accept) begin
                mainImm <= newImm;
                mainErr <= newErr;
                mainTag <= in_tag;
            end else begin
                mainValid <= 1'b0;
            end
        end else if (!mainValid) begin
            if (accept) begin
                mainValid <= 1'b1;
                mainImm   <= newImm;
                mainErr   <= newErr;
                mainTag   <= in_tag;
            end
        end else if (accept) begin
            skidValid <= 1'b1;
            skidImm   <= newImm;
            skidErr   <= newErr;
            skidTag   <= in_tag;
        end
    end

endmodule
